// File: rtl/rs422_pkg.sv
// Shared definitions for the RS422 framed link (transmit arbiter and receive demux).
// Holds sync defaults, type codes, channel indices, the receive FSM state encoding and the
// type-code decoder.
package rs422_pkg;

  localparam logic [7:0] SYNC0_DEF = 8'hEB;
  localparam logic [7:0] SYNC1_DEF = 8'h90;

  localparam int unsigned NUM_CH = 5;

  // Channel indices into every 5-bit per-channel vector
  localparam int unsigned CH_PF = 0;
  localparam int unsigned CH_DI = 1;
  localparam int unsigned CH_SD = 2;
  localparam int unsigned CH_HK = 3;
  localparam int unsigned CH_TC = 4;

  // TYPE byte codes
  localparam logic [7:0] TYPE_TC = 8'h01;
  localparam logic [7:0] TYPE_HK = 8'h02;
  localparam logic [7:0] TYPE_SD = 8'h03;
  localparam logic [7:0] TYPE_DI = 8'h04;
  localparam logic [7:0] TYPE_PF = 8'h05;

  typedef enum logic [5:0] {
    StHunt    = 6'b000001,
    StSync2   = 6'b000010,
    StType    = 6'b000100,
    StLen     = 6'b001000,
    StPayload = 6'b010000,
    StCsum    = 6'b100000
  } rx_state_e;

  // One-hot channel select for a TYPE byte; all-zero for an unknown code.
  function automatic logic [NUM_CH-1:0] type_to_chan(input logic [7:0] code);
    logic [NUM_CH-1:0] oh;
    oh = '0;
    case (code)
      TYPE_PF: oh[CH_PF] = 1'b1;
      TYPE_DI: oh[CH_DI] = 1'b1;
      TYPE_SD: oh[CH_SD] = 1'b1;
      TYPE_HK: oh[CH_HK] = 1'b1;
      TYPE_TC: oh[CH_TC] = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/rx_frame_timer.sv
// Inter-byte timeout counter for the receive framer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count (a byte arrived)
//   en         : count enable (a frame is being tracked)
//   expire     : high in the cycle the count reaches LIMIT-1 while enabled
module rx_frame_timer #(
  parameter logic [15:0] LIMIT = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;

  assign expire = en && (r_cnt == (LIMIT - 16'd1));

  // Restarting on expiry keeps the counter at zero while the framer sits in HUNT.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr || expire) begin
      w_cnt_nxt = '0;
    end else if (en) begin
      w_cnt_nxt = r_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/demux1to5_rx.sv
// Receive-side frame demultiplexer for the RS422 link.
// Finds SYNC0/SYNC1, decodes TYPE, streams the payload cut-through into one of five FIFOs,
// then checks the 8-bit additive checksum and reports per-channel good/bad frame status.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   rx_valid, rx_data   : byte strobe and byte from the UART receiver
//   full_*              : destination FIFO full flags
//   wen_*, dout         : destination FIFO write enables and shared write data
//   frame_ok, frame_bad : one-cycle per-channel frame status (bit0 pf .. bit4 tc)
//   err_*               : one-cycle error pulses
//   good_cnt, bad_cnt   : saturating frame counters
module demux1to5_rx
  import rs422_pkg::*;
#(
  parameter logic [7:0]  SYNC0       = SYNC0_DEF,
  parameter logic [7:0]  SYNC1       = SYNC1_DEF,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        full_pf,
  input  logic        full_di,
  input  logic        full_sd,
  input  logic        full_hk,
  input  logic        full_tc,
  output logic        wen_pf,
  output logic        wen_di,
  output logic        wen_sd,
  output logic        wen_hk,
  output logic        wen_tc,
  output logic [7:0]  dout,
  output logic [4:0]  frame_ok,
  output logic [4:0]  frame_bad,
  output logic        err_type,
  output logic        err_len,
  output logic        err_csum,
  output logic        err_ovf,
  output logic        err_tmo,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  rx_state_e         r_state, w_state_nxt;
  logic [NUM_CH-1:0] r_chan, w_chan_nxt;
  logic [7:0]        r_sum, w_sum_nxt;
  logic [7:0]        r_cnt, w_cnt_nxt;
  logic              r_ovf, w_ovf_nxt;

  logic [NUM_CH-1:0] r_wen, w_wen_nxt;
  logic [7:0]        r_dout, w_dout_nxt;
  logic [NUM_CH-1:0] r_ok, w_ok_nxt;
  logic [NUM_CH-1:0] r_bad, w_bad_nxt;
  logic              r_err_type, w_err_type;
  logic              r_err_len, w_err_len;
  logic              r_err_csum, w_err_csum;
  logic              r_err_ovf, w_err_ovf;
  logic              r_err_tmo, w_err_tmo;
  logic [15:0]       r_good_cnt, r_bad_cnt;
  logic              w_good_inc, w_bad_inc;

  logic [NUM_CH-1:0] w_full_vec;
  logic              w_sel_full;
  logic              w_expire;
  logic              w_timer_en;
  logic [NUM_CH-1:0] w_type_chan;

  assign w_full_vec[CH_PF] = full_pf;
  assign w_full_vec[CH_DI] = full_di;
  assign w_full_vec[CH_SD] = full_sd;
  assign w_full_vec[CH_HK] = full_hk;
  assign w_full_vec[CH_TC] = full_tc;

  assign w_sel_full  = |(r_chan & w_full_vec);
  assign w_type_chan = type_to_chan(rx_data);
  assign w_timer_en  = (r_state != StHunt);

  rx_frame_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (rx_valid),
    .en     (w_timer_en),
    .expire (w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_chan_nxt  = r_chan;
    w_sum_nxt   = r_sum;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    w_wen_nxt   = '0;
    w_dout_nxt  = r_dout;
    w_ok_nxt    = '0;
    w_bad_nxt   = '0;
    w_err_type  = 1'b0;
    w_err_len   = 1'b0;
    w_err_csum  = 1'b0;
    w_err_ovf   = 1'b0;
    w_err_tmo   = 1'b0;
    w_good_inc  = 1'b0;
    w_bad_inc   = 1'b0;

    // A byte arriving in the expiry cycle takes priority over the timeout.
    if (rx_valid) begin
      unique case (r_state)
        StHunt: begin
          if (rx_data == SYNC0) w_state_nxt = StSync2;
        end
        StSync2: begin
          if (rx_data == SYNC1) begin
            w_state_nxt = StType;
          end else if (rx_data != SYNC0) begin
            w_state_nxt = StHunt;
          end
        end
        StType: begin
          if (|w_type_chan) begin
            w_chan_nxt  = w_type_chan;
            w_sum_nxt   = rx_data;
            w_ovf_nxt   = 1'b0;
            w_state_nxt = StLen;
          end else begin
            w_err_type  = 1'b1;
            w_state_nxt = StHunt;
          end
        end
        StLen: begin
          if (rx_data == 8'd0) begin
            w_err_len   = 1'b1;
            w_bad_nxt   = r_chan;
            w_bad_inc   = 1'b1;
            w_state_nxt = StHunt;
          end else begin
            w_cnt_nxt   = rx_data;
            w_sum_nxt   = r_sum + rx_data;
            w_state_nxt = StPayload;
          end
        end
        StPayload: begin
          w_sum_nxt = r_sum + rx_data;
          w_cnt_nxt = r_cnt - 8'd1;
          if (w_sel_full) begin
            // Dropped byte poisons the frame; report the overflow only once per frame.
            w_err_ovf = !r_ovf;
            w_ovf_nxt = 1'b1;
          end else begin
            w_wen_nxt  = r_chan;
            w_dout_nxt = rx_data;
          end
          if (r_cnt == 8'd1) w_state_nxt = StCsum;
        end
        StCsum: begin
          if ((rx_data == r_sum) && !r_ovf) begin
            w_ok_nxt   = r_chan;
            w_good_inc = 1'b1;
          end else begin
            w_bad_nxt  = r_chan;
            w_bad_inc  = 1'b1;
            w_err_csum = (rx_data != r_sum);
          end
          w_ovf_nxt   = 1'b0;
          w_state_nxt = StHunt;
        end
        default: w_state_nxt = StHunt;
      endcase
    end else if (w_expire) begin
      w_err_tmo   = 1'b1;
      w_ovf_nxt   = 1'b0;
      w_state_nxt = StHunt;
      // A channel is only committed once TYPE has been accepted.
      if ((r_state == StLen) || (r_state == StPayload) || (r_state == StCsum)) begin
        w_bad_nxt = r_chan;
        w_bad_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StHunt;
      r_chan     <= '0;
      r_sum      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_wen      <= '0;
      r_dout     <= '0;
      r_ok       <= '0;
      r_bad      <= '0;
      r_err_type <= 1'b0;
      r_err_len  <= 1'b0;
      r_err_csum <= 1'b0;
      r_err_ovf  <= 1'b0;
      r_err_tmo  <= 1'b0;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_chan     <= w_chan_nxt;
      r_sum      <= w_sum_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ovf      <= w_ovf_nxt;
      r_wen      <= w_wen_nxt;
      r_dout     <= w_dout_nxt;
      r_ok       <= w_ok_nxt;
      r_bad      <= w_bad_nxt;
      r_err_type <= w_err_type;
      r_err_len  <= w_err_len;
      r_err_csum <= w_err_csum;
      r_err_ovf  <= w_err_ovf;
      r_err_tmo  <= w_err_tmo;
      if (w_good_inc && (r_good_cnt != 16'hFFFF)) r_good_cnt <= r_good_cnt + 16'd1;
      if (w_bad_inc && (r_bad_cnt != 16'hFFFF)) r_bad_cnt <= r_bad_cnt + 16'd1;
    end
  end

  assign wen_pf    = r_wen[CH_PF];
  assign wen_di    = r_wen[CH_DI];
  assign wen_sd    = r_wen[CH_SD];
  assign wen_hk    = r_wen[CH_HK];
  assign wen_tc    = r_wen[CH_TC];
  assign dout      = r_dout;
  assign frame_ok  = r_ok;
  assign frame_bad = r_bad;
  assign err_type  = r_err_type;
  assign err_len   = r_err_len;
  assign err_csum  = r_err_csum;
  assign err_ovf   = r_err_ovf;
  assign err_tmo   = r_err_tmo;
  assign good_cnt  = r_good_cnt;
  assign bad_cnt   = r_bad_cnt;

endmodule

// File: tb/tb_demux1to5_rx.sv
// Bench for demux1to5_rx: directed frames, a byte-level frame model checked every cycle,
// plus hand-computed expectations per scenario.
module tb_demux1to5_rx;

  localparam logic [15:0] TMO = 16'd40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [4:0]  tb_full;
  logic        wen_pf, wen_di, wen_sd, wen_hk, wen_tc;
  logic [7:0]  dout;
  logic [4:0]  frame_ok, frame_bad;
  logic        err_type, err_len, err_csum, err_ovf, err_tmo;
  logic [15:0] good_cnt, bad_cnt;

  always #5 clk = ~clk;

  demux1to5_rx #(
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .full_pf   (tb_full[0]),
    .full_di   (tb_full[1]),
    .full_sd   (tb_full[2]),
    .full_hk   (tb_full[3]),
    .full_tc   (tb_full[4]),
    .wen_pf    (wen_pf),
    .wen_di    (wen_di),
    .wen_sd    (wen_sd),
    .wen_hk    (wen_hk),
    .wen_tc    (wen_tc),
    .dout      (dout),
    .frame_ok  (frame_ok),
    .frame_bad (frame_bad),
    .err_type  (err_type),
    .err_len   (err_len),
    .err_csum  (err_csum),
    .err_ovf   (err_ovf),
    .err_tmo   (err_tmo),
    .good_cnt  (good_cnt),
    .bad_cnt   (bad_cnt)
  );

  logic [4:0] dut_wen, dut_err;
  assign dut_wen = {wen_tc, wen_hk, wen_sd, wen_di, wen_pf};
  // Error vector order: {type, len, csum, ovf, tmo}
  assign dut_err = {err_type, err_len, err_csum, err_ovf, err_tmo};

  int cnt_total = 0;
  int cnt_fail  = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    cnt_total++;
    if (act !== exp) begin
      cnt_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Expected outputs (current cycle) and next-cycle values from the model
  logic [4:0]  e_wen, e_ok, e_bad, e_err, n_wen, n_ok, n_bad, n_err;
  logic [7:0]  e_dout, n_dout;
  logic [15:0] e_good, e_badc, n_good, n_badc;

  // Frame model: sync window, bytes collected after sync, idle cycles, overflow flag
  bit         m_sync, m_pre, m_ovf;
  logic [7:0] m_body[$];
  int         m_idle, m_ch, m_len;

  function automatic int code2ch(input logic [7:0] c);
    case (c)
      8'h01: return 4;
      8'h02: return 3;
      8'h03: return 2;
      8'h04: return 1;
      8'h05: return 0;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_sync = 0; m_pre = 0; m_ovf = 0; m_idle = 0; m_ch = -1; m_len = 0;
    m_body.delete();
    n_wen = 0; n_ok = 0; n_bad = 0; n_err = 0; n_dout = 0; n_good = 0; n_badc = 0;
    e_wen = 0; e_ok = 0; e_bad = 0; e_err = 0; e_dout = 0; e_good = 0; e_badc = 0;
  endtask

  task automatic frame_bad_m(input int ch);
    n_bad[ch] = 1'b1;
    if (n_badc != 16'hFFFF) n_badc++;
  endtask

  task automatic model_step(input bit v, input logic [7:0] b, input logic [4:0] full);
    int n;
    logic [7:0] s;
    n_wen = 0; n_ok = 0; n_bad = 0; n_err = 0;
    if (v) begin
      m_idle = 0;
      if (!m_sync) begin
        if (m_pre && b == 8'h90) begin
          m_sync = 1; m_pre = 0; m_ovf = 0; m_body.delete();
        end else begin
          m_pre = (b == 8'hEB);
        end
      end else begin
        m_body.push_back(b);
        n = m_body.size();
        if (n == 1) begin
          m_ch = code2ch(b);
          if (m_ch < 0) begin n_err[4] = 1'b1; m_sync = 0; end
        end else if (n == 2) begin
          m_len = int'(b);
          if (b == 8'd0) begin n_err[3] = 1'b1; frame_bad_m(m_ch); m_sync = 0; end
        end else if (n <= m_len + 2) begin
          if (full[m_ch]) begin
            if (!m_ovf) n_err[1] = 1'b1;
            m_ovf = 1;
          end else begin
            n_wen[m_ch] = 1'b1;
            n_dout = b;
          end
        end else begin
          s = 8'd0;
          for (int i = 0; i < n - 1; i++) s = s + m_body[i];
          if (s == b && !m_ovf) begin
            n_ok[m_ch] = 1'b1;
            if (n_good != 16'hFFFF) n_good++;
          end else begin
            frame_bad_m(m_ch);
            if (s != b) n_err[2] = 1'b1;
          end
          m_sync = 0;
        end
      end
    end else if (m_sync || m_pre) begin
      m_idle++;
      if (m_idle == int'(TMO)) begin
        n_err[0] = 1'b1;
        if (m_sync && m_body.size() >= 1) frame_bad_m(m_ch);
        m_sync = 0; m_pre = 0;
      end
    end
  endtask

  task automatic tick(input bit v, input logic [7:0] b, input logic [4:0] full);
    rx_valid = v; rx_data = b; tb_full = full;
    model_step(v, b, full);
    @(posedge clk);
    #1;
    e_wen = n_wen; e_ok = n_ok; e_bad = n_bad; e_err = n_err;
    e_dout = n_dout; e_good = n_good; e_badc = n_badc;
  endtask

  logic [7:0] frm[$];

  task automatic play(input int fidx, input logic [4:0] fmask, input bit gap);
    foreach (frm[i]) begin
      tick(1'b1, frm[i], (i == fidx) ? fmask : 5'b0);
      if (gap) tick(1'b0, 8'h00, 5'b0);
    end
    repeat (3) tick(1'b0, 8'h00, 5'b0);
  endtask

  // Observations accumulated by the compare process for the directed checks
  bit         cmp_en = 0;
  int         obs_wen[5];
  int         obs_err[5];
  logic [7:0] obs_dout[$];
  logic [4:0] obs_ok, obs_bad;

  task automatic clear_obs();
    for (int k = 0; k < 5; k++) begin obs_wen[k] = 0; obs_err[k] = 0; end
    obs_dout.delete();
    obs_ok = 0; obs_bad = 0;
  endtask

  function automatic int wen_others(input int keep);
    int s = 0;
    for (int k = 0; k < 5; k++) if (k != keep) s += obs_wen[k];
    return s;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_wen", 64'(dut_wen), 64'(e_wen));
      chk("cyc_dout", 64'(dout), 64'(e_dout));
      chk("cyc_ok", 64'(frame_ok), 64'(e_ok));
      chk("cyc_bad", 64'(frame_bad), 64'(e_bad));
      chk("cyc_err", 64'(dut_err), 64'(e_err));
      chk("cyc_good_cnt", 64'(good_cnt), 64'(e_good));
      chk("cyc_bad_cnt", 64'(bad_cnt), 64'(e_badc));
      for (int k = 0; k < 5; k++) begin
        if (dut_wen[k]) obs_wen[k]++;
        if (dut_err[k]) obs_err[k]++;
      end
      if (|dut_wen) obs_dout.push_back(dout);
      obs_ok  = obs_ok | frame_ok;
      obs_bad = obs_bad | frame_bad;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tb_full = 5'b0;
    model_reset();
    clear_obs();
    #12;
    chk("reset_outputs", {dut_wen, dout, frame_ok, frame_bad, dut_err, good_cnt, bad_cnt}, 64'd0);
    cmp_en = 1;
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Good hk frame
    clear_obs();
    frm = '{8'hEB, 8'h90, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6B};
    play(-1, 5'b0, 1'b0);
    chk("hk_wen_count", obs_wen[3], 3);
    chk("hk_other_wen", wen_others(3), 0);
    chk("hk_dout_n", obs_dout.size(), 3);
    if (obs_dout.size() == 3) begin
      chk("hk_dout0", obs_dout[0], 8'h11);
      chk("hk_dout1", obs_dout[1], 8'h22);
      chk("hk_dout2", obs_dout[2], 8'h33);
    end
    chk("hk_ok", obs_ok, 5'b01000);
    chk("hk_good_cnt", good_cnt, 16'd1);

    // Sync pattern inside a tc payload is plain data; bytes spaced out
    clear_obs();
    frm = '{8'hEB, 8'h90, 8'h01, 8'h02, 8'hEB, 8'h90, 8'h7E};
    play(-1, 5'b0, 1'b1);
    chk("syncdata_wen_tc", obs_wen[4], 2);
    chk("syncdata_ok", obs_ok, 5'b10000);
    chk("syncdata_good_cnt", good_cnt, 16'd2);

    // Bad checksum on pf
    clear_obs();
    frm = '{8'hEB, 8'h90, 8'h05, 8'h01, 8'hAA, 8'h00};
    play(-1, 5'b0, 1'b0);
    chk("csum_wen_pf", obs_wen[0], 1);
    if (obs_dout.size() == 1) chk("csum_dout", obs_dout[0], 8'hAA);
    chk("csum_bad", obs_bad, 5'b00001);
    chk("csum_ok", obs_ok, 5'b00000);
    chk("csum_err", obs_err[2], 1);
    chk("csum_bad_cnt", bad_cnt, 16'd1);

    // Invalid type, then resync onto a tc frame
    clear_obs();
    frm = '{8'hEB, 8'hEB, 8'h90, 8'h07, 8'hEB, 8'h90, 8'h01, 8'h01, 8'h55, 8'h57};
    play(-1, 5'b0, 1'b0);
    chk("type_err", obs_err[4], 1);
    chk("type_bad", obs_bad, 5'b00000);
    chk("type_wen_tc", obs_wen[4], 1);
    if (obs_dout.size() == 1) chk("type_dout", obs_dout[0], 8'h55);
    chk("type_ok", obs_ok, 5'b10000);

    // Overflow: sd FIFO full for payload byte 2
    clear_obs();
    frm = '{8'hEB, 8'h90, 8'h03, 8'h03, 8'h01, 8'h02, 8'h03, 8'h0C};
    play(5, 5'b00100, 1'b0);
    chk("ovf_wen_sd", obs_wen[2], 2);
    chk("ovf_dout_n", obs_dout.size(), 2);
    if (obs_dout.size() == 2) begin
      chk("ovf_dout0", obs_dout[0], 8'h01);
      chk("ovf_dout1", obs_dout[1], 8'h03);
    end
    chk("ovf_err", obs_err[1], 1);
    chk("ovf_no_csum_err", obs_err[2], 0);
    chk("ovf_bad", obs_bad, 5'b00100);
    chk("ovf_ok", obs_ok, 5'b00000);

    // Timeout mid-payload on di, then a good frame
    clear_obs();
    frm = '{8'hEB, 8'h90, 8'h04, 8'h04, 8'h10, 8'h20};
    play(-1, 5'b0, 1'b0);
    repeat (int'(TMO) + 5) tick(1'b0, 8'h00, 5'b0);
    chk("tmo_err", obs_err[0], 1);
    chk("tmo_bad", obs_bad, 5'b00010);
    chk("tmo_bad_cnt", bad_cnt, 16'd3);
    clear_obs();
    frm = '{8'hEB, 8'h90, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6B};
    play(-1, 5'b0, 1'b0);
    chk("tmo_after_ok", obs_ok, 5'b01000);

    // Reset in the middle of a payload
    frm = '{8'hEB, 8'h90, 8'h02, 8'h03, 8'h11, 8'h22};
    foreach (frm[i]) tick(1'b1, frm[i], 5'b0);
    rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_outputs", {dut_wen, dout, frame_ok, frame_bad, dut_err, good_cnt, bad_cnt},
        64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_obs();
    repeat (5) tick(1'b0, 8'h00, 5'b0);
    chk("rst_no_pulse", {obs_ok, obs_bad}, 10'd0);
    frm = '{8'hEB, 8'h90, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6B};
    play(-1, 5'b0, 1'b0);
    chk("rst_after_ok", obs_ok, 5'b01000);
    chk("rst_after_good", good_cnt, 16'd1);

    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", cnt_total, cnt_fail);
    $finish;
  end

endmodule
